// File: rtl/tmds_channel_encoder.sv
// Single-channel TMDS 8b/10b encoder: video (transition-minimised, DC-balanced),
// control tokens and, in HDMI mode, TERC4 data-island symbols. Fixed 3-clock latency.
module tmds_channel_encoder #(
    parameter string CHANNEL = "BLUE",
    parameter string MODE    = "DVI"
) (
    input  logic       clkin,
    input  logic       rstin,
    input  logic [7:0] vdin,
    input  logic [3:0] adin,
    input  logic       c0,
    input  logic       c1,
    input  logic       vde,
    input  logic       ade,
    output logic [9:0] dout
);

    localparam bit IS_HDMI       = (MODE == "HDMI");
    localparam bit CHANNEL_KNOWN = (CHANNEL == "BLUE") || (CHANNEL == "GREEN") || (CHANNEL == "RED");

    // Channel identity only labels the instance; nothing hangs off it.
    generate
        if (!CHANNEL_KNOWN) begin : g_unknown_channel
        end
    endgenerate

    // ---------------- stage 1 ----------------
    logic [7:0] vdin_s1_reg;
    logic [3:0] adin_s1_reg;
    logic       c0_s1_reg, c1_s1_reg, vde_s1_reg, ade_s1_reg, vld_s1_reg;
    logic [3:0] n1d_s1_reg;
    logic [3:0] n1d_next;

    always_comb begin
        n1d_next = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1d_next = n1d_next + {3'b000, vdin[i]};
        end
    end

    always_ff @(posedge clkin or negedge rstin) begin
        if (!rstin) begin
            vdin_s1_reg <= '0;
            adin_s1_reg <= '0;
            c0_s1_reg   <= 1'b0;
            c1_s1_reg   <= 1'b0;
            vde_s1_reg  <= 1'b0;
            ade_s1_reg  <= 1'b0;
            vld_s1_reg  <= 1'b0;
            n1d_s1_reg  <= '0;
        end else begin
            vdin_s1_reg <= vdin;
            adin_s1_reg <= adin;
            c0_s1_reg   <= c0;
            c1_s1_reg   <= c1;
            vde_s1_reg  <= vde;
            ade_s1_reg  <= ade;
            vld_s1_reg  <= 1'b1;
            n1d_s1_reg  <= n1d_next;
        end
    end

    // ---------------- stage 2 ----------------
    logic [8:0] q_m_next;
    logic [3:0] n1q_next;
    logic       use_xnor;

    logic [8:0] q_m_s2_reg;
    logic [3:0] n1q_s2_reg, n0q_s2_reg;
    logic [3:0] adin_s2_reg;
    logic       c0_s2_reg, c1_s2_reg, vde_s2_reg, ade_s2_reg, vld_s2_reg;

    assign use_xnor = (n1d_s1_reg > 4'd4) || ((n1d_s1_reg == 4'd4) && !vdin_s1_reg[0]);

    always_comb begin
        q_m_next    = '0;
        q_m_next[0] = vdin_s1_reg[0];
        for (int i = 1; i < 8; i++) begin
            q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ vdin_s1_reg[i])
                                   :  (q_m_next[i-1] ^ vdin_s1_reg[i]);
        end
        q_m_next[8] = ~use_xnor;
        n1q_next = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1q_next = n1q_next + {3'b000, q_m_next[i]};
        end
    end

    always_ff @(posedge clkin or negedge rstin) begin
        if (!rstin) begin
            q_m_s2_reg  <= '0;
            n1q_s2_reg  <= '0;
            n0q_s2_reg  <= '0;
            adin_s2_reg <= '0;
            c0_s2_reg   <= 1'b0;
            c1_s2_reg   <= 1'b0;
            vde_s2_reg  <= 1'b0;
            ade_s2_reg  <= 1'b0;
            vld_s2_reg  <= 1'b0;
        end else begin
            q_m_s2_reg  <= q_m_next;
            n1q_s2_reg  <= n1q_next;
            n0q_s2_reg  <= 4'd8 - n1q_next;
            adin_s2_reg <= adin_s1_reg;
            c0_s2_reg   <= c0_s1_reg;
            c1_s2_reg   <= c1_s1_reg;
            vde_s2_reg  <= vde_s1_reg;
            ade_s2_reg  <= ade_s1_reg;
            vld_s2_reg  <= vld_s1_reg;
        end
    end

    // ---------------- stage 3 ----------------
    // cnt is a 5-bit two's-complement value; all arithmetic wraps mod 32.
    logic [4:0] cnt_reg, cnt_next;
    logic [9:0] dout_next, video_sym, ctrl_sym, terc4_sym;
    logic [4:0] diff;
    logic       q8, cnt_zero, cnt_neg, balanced, invert_b;

    assign q8       = q_m_s2_reg[8];
    assign diff     = {1'b0, n1q_s2_reg} - {1'b0, n0q_s2_reg};
    assign cnt_zero = (cnt_reg == 5'd0);
    assign cnt_neg  = cnt_reg[4];
    assign balanced = cnt_zero || (n1q_s2_reg == n0q_s2_reg);
    assign invert_b = (!cnt_neg && !cnt_zero && (n1q_s2_reg > n0q_s2_reg)) ||
                      (cnt_neg && (n0q_s2_reg > n1q_s2_reg));

    always_comb begin
        video_sym = '0;
        cnt_next  = cnt_reg;
        if (balanced) begin
            video_sym = {~q8, q8, q8 ? q_m_s2_reg[7:0] : ~q_m_s2_reg[7:0]};
            cnt_next  = q8 ? (cnt_reg + diff) : (cnt_reg - diff);
        end else if (invert_b) begin
            video_sym = {1'b1, q8, ~q_m_s2_reg[7:0]};
            cnt_next  = cnt_reg + {3'b000, q8, 1'b0} - diff;
        end else begin
            video_sym = {1'b0, q8, q_m_s2_reg[7:0]};
            cnt_next  = cnt_reg - {3'b000, ~q8, 1'b0} + diff;
        end
    end

    always_comb begin
        ctrl_sym = 10'h354;
        case ({c1_s2_reg, c0_s2_reg})
            2'b00: ctrl_sym = 10'h354;
            2'b01: ctrl_sym = 10'h0AB;
            2'b10: ctrl_sym = 10'h154;
            2'b11: ctrl_sym = 10'h2AB;
            default: ctrl_sym = 10'h354;
        endcase
    end

    always_comb begin
        terc4_sym = 10'b1010011100;
        case (adin_s2_reg)
            4'h0: terc4_sym = 10'b1010011100;
            4'h1: terc4_sym = 10'b1001100011;
            4'h2: terc4_sym = 10'b1011100100;
            4'h3: terc4_sym = 10'b1011100010;
            4'h4: terc4_sym = 10'b0101110001;
            4'h5: terc4_sym = 10'b0100011110;
            4'h6: terc4_sym = 10'b0110001110;
            4'h7: terc4_sym = 10'b0100111100;
            4'h8: terc4_sym = 10'b1011001100;
            4'h9: terc4_sym = 10'b0100111001;
            4'hA: terc4_sym = 10'b0110011100;
            4'hB: terc4_sym = 10'b1011000110;
            4'hC: terc4_sym = 10'b1010001110;
            4'hD: terc4_sym = 10'b1001110001;
            4'hE: terc4_sym = 10'b0101100011;
            4'hF: terc4_sym = 10'b1011000011;
            default: terc4_sym = 10'b1010011100;
        endcase
    end

    assign dout_next = vde_s2_reg                ? video_sym :
                       (IS_HDMI && ade_s2_reg)   ? terc4_sym : ctrl_sym;

    // dout holds 0 until the first sampled input reaches this stage after reset.
    always_ff @(posedge clkin or negedge rstin) begin
        if (!rstin) begin
            dout    <= '0;
            cnt_reg <= '0;
        end else if (vld_s2_reg) begin
            dout    <= dout_next;
            cnt_reg <= vde_s2_reg ? cnt_next : 5'd0;
        end
    end

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: one HDMI and one DVI instance share
// stimulus; a reference model queues expected symbols that pop 3 clocks later.
module tb_tmds_channel_encoder;

    logic       clkin = 1'b0;
    logic       rstin = 1'b0;
    logic [7:0] vdin  = '0;
    logic [3:0] adin  = '0;
    logic       c0 = 1'b0, c1 = 1'b0, vde = 1'b0, ade = 1'b0;
    logic [9:0] dout_hdmi, dout_dvi;

    always #5 clkin = ~clkin;

    tmds_channel_encoder #(.CHANNEL("GREEN"), .MODE("HDMI")) dut_hdmi (
        .clkin(clkin), .rstin(rstin), .vdin(vdin), .adin(adin),
        .c0(c0), .c1(c1), .vde(vde), .ade(ade), .dout(dout_hdmi));

    tmds_channel_encoder #(.CHANNEL("BLUE"), .MODE("DVI")) dut_dvi (
        .clkin(clkin), .rstin(rstin), .vdin(vdin), .adin(adin),
        .c0(c0), .c1(c1), .vde(vde), .ade(ade), .dout(dout_dvi));

    typedef struct {
        logic [9:0] exp_hdmi;
        logic [9:0] exp_dvi;
        logic [7:0] vd;
        bit         video;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    int  model_cnt = 0;

    logic [9:0] ctrl_tbl  [0:3]  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    logic [9:0] terc4_tbl [0:15] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    task automatic model_video(input logic [7:0] d, output logic [9:0] sym);
        int n1, a, b;
        bit xn, q8;
        logic [7:0] q;
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q8 = !xn;
        a = $countones(q);
        b = 8 - a;
        if (model_cnt == 0 || a == b) begin
            sym = q8 ? {2'b01, q} : {2'b10, ~q};
            model_cnt += q8 ? (a - b) : (b - a);
        end else if ((model_cnt > 0 && a > b) || (model_cnt < 0 && b > a)) begin
            sym = {1'b1, q8, ~q};
            model_cnt += 2 * int'(q8) + b - a;
        end else begin
            sym = {1'b0, q8, q};
            model_cnt += -2 * int'(!q8) + a - b;
        end
    endtask

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] q, d;
        q = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    // Drives one clock of stimulus, queues its expected symbols, and hands back
    // the entry whose symbol is now on dout (3-deep pipeline).
    task automatic drive(input logic [7:0] vd, input logic [3:0] ad, input bit cc1, input bit cc0,
                         input bit v, input bit a, output bit got, output sb_t e);
        sb_t n;
        vdin = vd; adin = ad; c1 = cc1; c0 = cc0; vde = v; ade = a;
        n.vd = vd;
        n.video = v;
        if (v) begin
            model_video(vd, n.exp_hdmi);
            n.exp_dvi = n.exp_hdmi;
        end else if (a) begin
            n.exp_hdmi = terc4_tbl[ad];
            n.exp_dvi  = ctrl_tbl[{cc1, cc0}];
            model_cnt  = 0;
        end else begin
            n.exp_hdmi = ctrl_tbl[{cc1, cc0}];
            n.exp_dvi  = n.exp_hdmi;
            model_cnt  = 0;
        end
        sb_q.push_back(n);
        @(posedge clkin);
        #1;
        got = 1'b0;
        e = n;
        if (sb_q.size() == 3) begin
            e = sb_q.pop_front();
            got = 1'b1;
        end
    endtask

    task automatic restart_pipeline();
        sb_t z;
        z.exp_hdmi = '0; z.exp_dvi = '0; z.vd = '0; z.video = 1'b0;
        sb_q.delete();
        sb_q.push_back(z);
        sb_q.push_back(z);
        model_cnt = 0;
    endtask

    task automatic test_reset();
        bit got; sb_t e;
        for (int k = 0; k < 4; k++) begin
            rstin = 1'b0; vde = 1'b0; ade = 1'b0; c1 = k[1]; c0 = k[0];
            @(posedge clkin); #1;
            checks++;
            if (dout_hdmi !== 10'h000) begin errors++; $display("FAIL reset_hdmi: got %h required 000", dout_hdmi); end
            checks++;
            if (dout_dvi !== 10'h000) begin errors++; $display("FAIL reset_dvi: got %h required 000", dout_dvi); end
            @(negedge clkin);
            rstin = 1'b1;
            restart_pipeline();
            for (int j = 0; j < 6; j++) begin
                drive(8'h00, 4'h0, k[1], k[0], 1'b0, 1'b0, got, e);
                if (got) begin
                    checks++;
                    if (dout_hdmi !== e.exp_hdmi) begin errors++; $display("FAIL ctrl_token_hdmi c=%0d cyc=%0d: got %h required %h", k, j, dout_hdmi, e.exp_hdmi); end
                    checks++;
                    if (dout_dvi !== e.exp_dvi) begin errors++; $display("FAIL ctrl_token_dvi c=%0d cyc=%0d: got %h required %h", k, j, dout_dvi, e.exp_dvi); end
                end
            end
        end
    endtask

    task automatic test_video_zero_run();
        bit got; sb_t e;
        logic [9:0] seen [$];
        logic [9:0] want [0:2] = '{10'h100, 10'h3FF, 10'h100};
        bit v_seq [0:8] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        for (int j = 0; j < 9; j++) begin
            drive(8'h00, 4'h0, 1'b0, 1'b0, v_seq[j], 1'b0, got, e);
            if (got) begin
                checks++;
                if (dout_hdmi !== e.exp_hdmi) begin errors++; $display("FAIL zero_run_hdmi cyc=%0d: got %h required %h", j, dout_hdmi, e.exp_hdmi); end
                checks++;
                if (dout_dvi !== e.exp_dvi) begin errors++; $display("FAIL zero_run_dvi cyc=%0d: got %h required %h", j, dout_dvi, e.exp_dvi); end
                if (e.video) seen.push_back(dout_hdmi);
            end
        end
        checks++;
        if (seen.size() != 3) begin
            errors++; $display("FAIL zero_run_count: got %0d required 3", seen.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (seen[i] !== want[i]) begin errors++; $display("FAIL zero_run_seq[%0d]: got %h required %h", i, seen[i], want[i]); end
            end
        end
    endtask

    task automatic test_video_ff();
        bit got; sb_t e;
        int nvid = 0;
        bit v_seq [0:6] = '{0, 0, 0, 1, 0, 0, 0};
        for (int j = 0; j < 7; j++) begin
            drive(8'hFF, 4'h0, 1'b1, 1'b0, v_seq[j], 1'b0, got, e);
            if (got) begin
                checks++;
                if (dout_hdmi !== e.exp_hdmi) begin errors++; $display("FAIL ff_hdmi cyc=%0d: got %h required %h", j, dout_hdmi, e.exp_hdmi); end
                if (e.video) begin
                    nvid++;
                    checks++;
                    if (dout_dvi !== 10'h200) begin errors++; $display("FAIL ff_symbol: got %h required 200", dout_dvi); end
                end
            end
        end
        checks++;
        if (nvid != 1) begin errors++; $display("FAIL ff_count: got %0d required 1", nvid); end
    endtask

    task automatic test_ctrl_clears_cnt();
        bit got; sb_t e;
        int vid_after_ctrl = 0;
        bit seen_ctrl = 0;
        for (int j = 0; j < 12; j++) begin
            bit v;
            logic [7:0] d;
            v = (j != 6) && (j < 9);
            d = (j > 6) ? 8'h00 : 8'(j * 37 + 5);
            drive(d, 4'h0, 1'b0, 1'b1, v, 1'b0, got, e);
            if (got) begin
                checks++;
                if (dout_hdmi !== e.exp_hdmi) begin errors++; $display("FAIL ctrl_clear_hdmi cyc=%0d: got %h required %h", j, dout_hdmi, e.exp_hdmi); end
                checks++;
                if (dout_dvi !== e.exp_dvi) begin errors++; $display("FAIL ctrl_clear_dvi cyc=%0d: got %h required %h", j, dout_dvi, e.exp_dvi); end
                if (!e.video && j > 6) seen_ctrl = 1;
                if (e.video && seen_ctrl && vid_after_ctrl == 0) begin
                    vid_after_ctrl++;
                    checks++;
                    if (dout_hdmi !== 10'h100) begin errors++; $display("FAIL resume_after_ctrl: got %h required 100", dout_hdmi); end
                end
            end
        end
        checks++;
        if (vid_after_ctrl != 1) begin errors++; $display("FAIL resume_seen: got %0d required 1", vid_after_ctrl); end
    endtask

    task automatic test_terc4_sweep();
        bit got; sb_t e;
        for (int j = 0; j < 19; j++) begin
            logic [3:0] ad;
            ad = 4'(j);
            drive(8'h5A, ad, ad[1], ad[0], 1'b0, (j < 16), got, e);
            if (got) begin
                checks++;
                if (dout_hdmi !== e.exp_hdmi) begin errors++; $display("FAIL terc4_hdmi cyc=%0d: got %h required %h", j, dout_hdmi, e.exp_hdmi); end
                checks++;
                if (dout_dvi !== e.exp_dvi) begin errors++; $display("FAIL terc4_dvi_ctrl cyc=%0d: got %h required %h", j, dout_dvi, e.exp_dvi); end
            end
        end
        // Video wins over aux enable when both are high.
        for (int j = 0; j < 4; j++) begin
            drive(8'h3C, 4'h7, 1'b0, 1'b0, (j == 0), 1'b1, got, e);
            if (got) begin
                checks++;
                if (dout_hdmi !== e.exp_hdmi) begin errors++; $display("FAIL vde_priority cyc=%0d: got %h required %h", j, dout_hdmi, e.exp_hdmi); end
            end
        end
    endtask

    task automatic test_random_stream();
        bit got; sb_t e;
        int run_disp = 0;
        for (int j = 0; j < 10003; j++) begin
            drive(8'($urandom_range(0, 255)), 4'h0, 1'b0, 1'b0, (j < 10000), 1'b0, got, e);
            if (got) begin
                checks++;
                if (dout_hdmi !== e.exp_hdmi) begin errors++; $display("FAIL rand_hdmi cyc=%0d: got %h required %h", j, dout_hdmi, e.exp_hdmi); end
                checks++;
                if (dout_dvi !== e.exp_dvi) begin errors++; $display("FAIL rand_dvi cyc=%0d: got %h required %h", j, dout_dvi, e.exp_dvi); end
                if (e.video) begin
                    run_disp += 2 * $countones(dout_hdmi) - 10;
                    checks++;
                    if (decode(dout_hdmi) !== e.vd) begin errors++; $display("FAIL rand_decode cyc=%0d: got %h required %h", j, decode(dout_hdmi), e.vd); end
                    checks++;
                    if (run_disp > 8 || run_disp < -8) begin errors++; $display("FAIL rand_disparity cyc=%0d: got %0d required within -8..8", j, run_disp); end
                end else begin
                    run_disp = 0;
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bit got; sb_t e;
        int nvid = 0;
        logic [9:0] want [0:1] = '{10'h100, 10'h3FF};
        for (int j = 0; j < 5; j++) begin
            drive(8'($urandom_range(0, 255)), 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, got, e);
            if (got) begin
                checks++;
                if (dout_hdmi !== e.exp_hdmi) begin errors++; $display("FAIL pre_reset_hdmi cyc=%0d: got %h required %h", j, dout_hdmi, e.exp_hdmi); end
            end
        end
        #2;
        rstin = 1'b0;
        #1;
        checks++;
        if (dout_hdmi !== 10'h000) begin errors++; $display("FAIL async_clear_hdmi: got %h required 000", dout_hdmi); end
        checks++;
        if (dout_dvi !== 10'h000) begin errors++; $display("FAIL async_clear_dvi: got %h required 000", dout_dvi); end
        @(negedge clkin);
        rstin = 1'b1;
        restart_pipeline();
        for (int j = 0; j < 7; j++) begin
            drive(8'h00, 4'h0, 1'b1, 1'b1, (j < 2), 1'b0, got, e);
            if (got) begin
                checks++;
                if (dout_hdmi !== e.exp_hdmi) begin errors++; $display("FAIL post_reset_hdmi cyc=%0d: got %h required %h", j, dout_hdmi, e.exp_hdmi); end
                if (e.video) begin
                    checks++;
                    if (dout_dvi !== want[nvid]) begin errors++; $display("FAIL post_reset_seq[%0d]: got %h required %h", nvid, dout_dvi, want[nvid]); end
                    nvid++;
                end
            end
        end
        checks++;
        if (nvid != 2) begin errors++; $display("FAIL post_reset_count: got %0d required 2", nvid); end
    endtask

    initial begin
        test_reset();
        test_video_zero_run();
        test_video_ff();
        test_ctrl_clears_cnt();
        test_terc4_sweep();
        test_random_stream();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
